// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Shift-add multiply and restoring divide, one bit per cycle, fixed XLEN-cycle latency.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   rem_new;
  logic [ACC_W-1:0]  acc_step;
  logic [ACC_W-1:0]  prod_fin;
  logic [XLEN-1:0]   quo, rem, res;

  // Operand sign decode and magnitude conversion at accept time
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:             a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & A_i[XLEN-1];
    b_neg = b_sgn & B_i[XLEN-1];
    a_mag = a_neg ? -A_i : A_i;
    b_mag = b_neg ? -B_i : B_i;
  end

  // One datapath iteration; acc holds {hi, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_sh   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    div_ge   = rem_sh >= {1'b0, opd_q};
    rem_new  = div_ge ? (rem_sh[XLEN-1:0] - opd_q) : rem_sh[XLEN-1:0];
    acc_step = op_q[2] ? {rem_new, acc_q[XLEN-2:0], div_ge}
                       : {mul_sum, acc_q[XLEN-1:1]};
    prod_fin = neg_q ? -acc_step : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[ACC_W-1:XLEN];
    case (op_q)
      3'd0:             res = acc_step[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod_fin[ACC_W-1:XLEN];
      3'd4, 3'd5:       res = neg_q ? -quo : quo;
      default:          res = neg_q ? -rem : rem;
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_CALC;
          op_d    = op_i;
          count_d = '0;
          opd_d   = op_i[2] ? b_mag : a_mag;
          acc_d   = op_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          case (op_i)
            3'd1:    neg_d = a_neg ^ b_neg;
            3'd4:    neg_d = (a_neg ^ b_neg) & (B_i != '0);
            3'd2,
            3'd6:    neg_d = a_neg;
            default: neg_d = 1'b0;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(XLEN - 1)) begin
          state_d  = S_DONE;
          result_d = res;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
